obi_outstanding_buffer: RTL and testbench

- Registered OBI request queue with outstanding-transaction tracking.
- Sits between the N-to-1 external-master crossbar output (ext_master_bus_req/resp) and the mochila_top external master port.
- Breaks every combinational gnt/req path between the two sides.
- Caps in-flight transactions and registers responses back upstream.

---
 rtl/obi_outstanding_buffer.sv | 126 ++++++++++++
 tb/tb_obi_outstanding_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_outstanding_buffer.sv
// Registered OBI request queue between the external-master crossbar and mochila_top.
// Caps in-flight transactions and returns responses upstream through one register stage.
package obi_outstanding_buffer_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module obi_outstanding_buffer
    import obi_outstanding_buffer_pkg::*;
#(
    parameter  int unsigned REQ_DEPTH       = 2,
    parameter  int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  obi_req_t         slave_req_i,
    output obi_resp_t        slave_resp_o,
    output obi_req_t         master_req_o,
    input  obi_resp_t        master_resp_i,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             protocol_err_o
);

    localparam int unsigned PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(REQ_DEPTH + 1);

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } entry_t;

    entry_t             mem [REQ_DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [OCC_W-1:0]   occ;
    logic [CNT_W-1:0]   cnt;
    logic               rvalid_q;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic full, empty, gnt, push, pop, rsp_ok;

    // Grant depends only on registered state, so no gnt path crosses the buffer.
    assign full   = (occ == OCC_W'(REQ_DEPTH));
    assign empty  = (occ == '0);
    assign gnt    = !full && (cnt < CNT_W'(MAX_OUTSTANDING));
    assign push   = slave_req_i.req && gnt;
    assign pop    = !empty && master_resp_i.gnt;
    assign rsp_ok = master_resp_i.rvalid && (cnt != '0);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(REQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < int'(REQ_DEPTH); i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[tail] <= '{we: slave_req_i.we, be: slave_req_i.be,
                               addr: slave_req_i.addr, wdata: slave_req_i.wdata};
                tail      <= next_ptr(tail);
            end
            if (pop) head <= next_ptr(head);
            if (push && !pop)      occ <= occ + 1'b1;
            else if (!push && pop) occ <= occ - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (push && !rsp_ok) begin
            cnt <= cnt + 1'b1;
        end else if (!push && rsp_ok) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A response with nothing outstanding is dropped and flagged until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rsp_ok;
            if (rsp_ok) rdata_q <= master_resp_i.rdata;
            if (master_resp_i.rvalid && (cnt == '0)) err_q <= 1'b1;
        end
    end

    always_comb begin
        master_req_o = '0;
        if (!empty) begin
            master_req_o.req   = 1'b1;
            master_req_o.we    = mem[head].we;
            master_req_o.be    = mem[head].be;
            master_req_o.addr  = mem[head].addr;
            master_req_o.wdata = mem[head].wdata;
        end
    end

    assign slave_resp_o   = '{gnt: gnt, rvalid: rvalid_q, rdata: rdata_q};
    assign outstanding_o  = cnt;
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_obi_outstanding_buffer.sv
// Bench for obi_outstanding_buffer: vector table, directed corner sequences and
// a randomized run checked against a queue-based reference model.
module tb_obi_outstanding_buffer;
    import obi_outstanding_buffer_pkg::*;

    localparam int REQ_DEPTH = 2;
    localparam int MAX_OUT   = 4;
    localparam int CNT_W     = $clog2(MAX_OUT + 1);

    logic             clk;
    logic             rst_n;
    obi_req_t         sreq;
    obi_resp_t        sresp;
    obi_req_t         mreq;
    obi_resp_t        mresp;
    logic [CNT_W-1:0] outst;
    logic             perr;

    obi_outstanding_buffer #(.REQ_DEPTH(REQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .slave_req_i(sreq), .slave_resp_o(sresp),
        .master_req_o(mreq), .master_resp_i(mresp), .outstanding_o(outst),
        .protocol_err_o(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of accepted-but-not-issued requests and a count.
    obi_req_t    m_q[$];
    int          m_cnt;
    logic        m_rv;
    logic [31:0] m_rdata;
    logic        m_err;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt = 0; m_rv = 0; m_rdata = '0; m_err = 0;
    endtask

    function automatic logic model_gnt();
        return (m_q.size() < REQ_DEPTH) && (m_cnt < MAX_OUT);
    endfunction

    task automatic model_update();
        logic acc, cap;
        obi_req_t e;
        acc = sreq.req && model_gnt();
        cap = mresp.rvalid && (m_cnt > 0);
        if (mresp.rvalid && m_cnt == 0) m_err = 1;
        if (m_q.size() > 0 && mresp.gnt) void'(m_q.pop_front());
        if (acc) begin
            e = sreq;
            m_q.push_back(e);
        end
        m_cnt = m_cnt + int'(acc) - int'(cap);
        m_rv  = cap;
        if (cap) m_rdata = mresp.rdata;
    endtask

    // Compare against the model mid-cycle, then advance one clock.
    task automatic step();
        obi_req_t exp_m;
        @(negedge clk);
        exp_m = (m_q.size() > 0) ? m_q[0] : '0;
        chk("m_gnt", 70'(sresp.gnt), 70'(model_gnt()));
        chk("m_rvalid", 70'(sresp.rvalid), 70'(m_rv));
        chk("m_rdata", 70'(sresp.rdata), 70'(m_rdata));
        chk("m_master_req", 70'(mreq), 70'(exp_m));
        chk("m_outstanding", 70'(outst), 70'(m_cnt));
        chk("m_err", 70'(perr), 70'(m_err));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_in();
        sreq = '0;
        mresp = '0;
    endtask

    task automatic drain();
        sreq.req = 1'b0;
        mresp = '0;
        mresp.gnt = 1'b1;
        for (int i = 0; i < 20 && (m_cnt > 0 || m_q.size() > 0); i++) begin
            mresp.rvalid = (m_cnt > 0);
            mresp.rdata  = 32'hA000_0000 + i;
            step();
        end
        idle_in();
        step();
    endtask

    typedef struct {
        logic        sreq;
        logic        swe;
        logic [31:0] saddr;
        logic        mgnt;
        logic        mrv;
        logic [31:0] mrdata;
        logic        e_gnt;
        logic        e_mreq;
        logic [31:0] e_maddr;
        logic        e_rv;
        logic [31:0] e_rdata;
        int          e_out;
        logic        e_err;
    } vec_t;

    vec_t vec[7];
    int   acc_n;

    initial begin
        // single read, then a spurious response with nothing outstanding
        vec[0] = '{1, 0, 32'h1000, 0, 0, 32'h0,         1, 0, 32'h0,    0, 32'h0,         0, 0};
        vec[1] = '{0, 0, 32'h0,    1, 0, 32'h0,         1, 1, 32'h1000, 0, 32'h0,         1, 0};
        vec[2] = '{0, 0, 32'h0,    0, 0, 32'h0,         1, 0, 32'h0,    0, 32'h0,         1, 0};
        vec[3] = '{0, 0, 32'h0,    0, 1, 32'hDEADBEEF,  1, 0, 32'h0,    0, 32'h0,         1, 0};
        vec[4] = '{0, 0, 32'h0,    0, 0, 32'h0,         1, 0, 32'h0,    1, 32'hDEADBEEF,  0, 0};
        vec[5] = '{0, 0, 32'h0,    0, 1, 32'h1234,      1, 0, 32'h0,    0, 32'hDEADBEEF,  0, 0};
        vec[6] = '{0, 0, 32'h0,    0, 0, 32'h0,         1, 0, 32'h0,    0, 32'hDEADBEEF,  0, 1};

        idle_in();
        model_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_gnt", 70'(sresp.gnt), 70'(1));
        chk("rst_rvalid", 70'(sresp.rvalid), 70'(0));
        chk("rst_rdata", 70'(sresp.rdata), 70'(0));
        chk("rst_master_req", 70'(mreq), 70'(0));
        chk("rst_outstanding", 70'(outst), 70'(0));
        chk("rst_err", 70'(perr), 70'(0));
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // vector table
        for (int i = 0; i < 7; i++) begin
            idle_in();
            sreq.req  = vec[i].sreq;
            sreq.we   = vec[i].swe;
            sreq.addr = vec[i].saddr;
            sreq.be   = vec[i].sreq ? 4'hF : 4'h0;
            mresp.gnt    = vec[i].mgnt;
            mresp.rvalid = vec[i].mrv;
            mresp.rdata  = vec[i].mrdata;
            chk($sformatf("v%0d_gnt", i), 70'(sresp.gnt), 70'(vec[i].e_gnt));
            chk($sformatf("v%0d_mreq", i), 70'(mreq.req), 70'(vec[i].e_mreq));
            chk($sformatf("v%0d_maddr", i), 70'(mreq.addr), 70'(vec[i].e_maddr));
            chk($sformatf("v%0d_rvalid", i), 70'(sresp.rvalid), 70'(vec[i].e_rv));
            chk($sformatf("v%0d_rdata", i), 70'(sresp.rdata), 70'(vec[i].e_rdata));
            chk($sformatf("v%0d_outst", i), 70'(outst), 70'(vec[i].e_out));
            chk($sformatf("v%0d_err", i), 70'(perr), 70'(vec[i].e_err));
            step();
        end
        idle_in();
        for (int i = 0; i < 100; i++) step();
        chk("err_sticky", 70'(perr), 70'(1));
        chk("err_no_rvalid", 70'(sresp.rvalid), 70'(0));

        // reset mid-operation: two queued, three outstanding
        sreq = '0; sreq.req = 1; sreq.addr = 32'h20; mresp = '0;
        step();
        sreq.addr = 32'h24;
        step();
        chk("full_before_pop", 70'(sresp.gnt), 70'(0));
        sreq.req = 0; mresp.gnt = 1;
        step();
        sreq.req = 1; sreq.addr = 32'h28; mresp.gnt = 0;
        step();
        idle_in();
        chk("pre_rst_outst", 70'(outst), 70'(3));
        chk("pre_rst_mreq", 70'(mreq.req), 70'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mreq", 70'(mreq.req), 70'(0));
        chk("arst_outst", 70'(outst), 70'(0));
        chk("arst_gnt", 70'(sresp.gnt), 70'(1));
        chk("arst_err", 70'(perr), 70'(0));
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        sreq.req = 1; sreq.addr = 32'h3000;
        step();
        sreq.req = 0; mresp.gnt = 1;
        step();
        mresp = '0; mresp.rvalid = 1; mresp.rdata = 32'h0BAD_F00D;
        step();
        idle_in();
        chk("post_rst_rvalid", 70'(sresp.rvalid), 70'(1));
        chk("post_rst_rdata", 70'(sresp.rdata), 70'(32'h0BAD_F00D));
        step();

        // FIFO full: downstream grant withheld, three back-to-back writes
        sreq = '0; sreq.req = 1; sreq.we = 1; sreq.be = 4'hF;
        sreq.addr = 32'h10; sreq.wdata = 32'h1;
        chk("full_g0", 70'(sresp.gnt), 70'(1));
        step();
        sreq.addr = 32'h14; sreq.wdata = 32'h2;
        chk("full_g1", 70'(sresp.gnt), 70'(1));
        step();
        sreq.addr = 32'h18; sreq.wdata = 32'h3;
        chk("full_g2", 70'(sresp.gnt), 70'(0));
        step();
        mresp.gnt = 1;
        chk("full_issue0", 70'(mreq.addr), 70'(32'h10));
        chk("full_pop_gnt", 70'(sresp.gnt), 70'(0));
        step();
        chk("full_issue1", 70'(mreq.addr), 70'(32'h14));
        chk("full_third_gnt", 70'(sresp.gnt), 70'(1));
        step();
        sreq.req = 0;
        chk("full_issue2", 70'(mreq.addr), 70'(32'h18));
        step();
        drain();

        // outstanding cap
        acc_n = 0;
        mresp = '0; mresp.gnt = 1;
        for (int i = 0; i < 8; i++) begin
            sreq = '0; sreq.req = 1; sreq.addr = 32'h100 + 4 * i;
            if (sresp.gnt) acc_n++;
            step();
        end
        chk("cap_accepts", 70'(acc_n), 70'(4));
        chk("cap_outst", 70'(outst), 70'(4));
        chk("cap_gnt", 70'(sresp.gnt), 70'(0));
        sreq.req = 0; mresp.rvalid = 1; mresp.rdata = 32'h55;
        step();
        mresp.rvalid = 0;
        chk("cap_regnt", 70'(sresp.gnt), 70'(1));
        chk("cap_outst3", 70'(outst), 70'(3));
        drain();

        // simultaneous accept and response at cnt=2
        mresp = '0; mresp.gnt = 1;
        sreq = '0; sreq.req = 1; sreq.addr = 32'h200;
        step();
        sreq.addr = 32'h204;
        step();
        chk("sim_outst_pre", 70'(outst), 70'(2));
        sreq.addr = 32'h208; mresp.rvalid = 1; mresp.rdata = 32'h77;
        step();
        sreq.req = 0; mresp.rvalid = 0;
        chk("sim_outst", 70'(outst), 70'(2));
        chk("sim_rvalid", 70'(sresp.rvalid), 70'(1));
        chk("sim_rdata", 70'(sresp.rdata), 70'(32'h77));
        drain();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            sreq.req   = ($urandom_range(0, 1) == 1);
            sreq.we    = $urandom_range(0, 1);
            sreq.be    = 4'($urandom);
            sreq.addr  = $urandom;
            sreq.wdata = $urandom;
            mresp.gnt  = ($urandom_range(0, 9) < 6);
            mresp.rvalid = (m_cnt > 0) ? ($urandom_range(0, 9) < 3)
                                       : ($urandom_range(0, 99) < 2);
            mresp.rdata  = $urandom;
            step();
        end
        idle_in();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
